// File: rtl/dlx_pipeline_if.sv
// rtl/dlx_pipeline_if.sv - instruction fetch and data RAM bus of the dlx pipeline
interface dlx_pipeline_if;
  logic [31:0] pc;
  logic [31:0] inst_in;
  logic [31:0] memdata_in;
  logic [31:0] memdata_out;
  logic [31:0] mem_addr;
  logic        mem_wr_en;

  modport master (output pc, memdata_out, mem_addr, mem_wr_en, input inst_in, memdata_in);
  modport slave  (input pc, memdata_out, mem_addr, mem_wr_en, output inst_in, memdata_in);
endinterface

// File: rtl/dlx_pipeline.sv
// rtl/dlx_pipeline.sv - five-stage in-order DLX integer pipeline, redirects resolved in MEM
module dlx_pipeline #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic           clock,
  input  logic           reset,
  dlx_pipeline_if.master bus,
  output logic [31:0]    regs1,  regs2,  regs3,  regs4,  regs5,  regs6,  regs7,  regs8,
  output logic [31:0]    regs9,  regs10, regs11, regs12, regs13, regs14, regs15, regs16,
  output logic [31:0]    regs17, regs18, regs19, regs20, regs21, regs22, regs23, regs24,
  output logic [31:0]    regs25, regs26, regs27, regs28, regs29, regs30, regs31,
  output logic           branch_en,
  output logic           jump_en,
  output logic [31:0]    alu_branch,
  output logic [31:0]    alu_out34
);
  localparam logic [5:0] OP_LW   = 6'b000101, OP_SW   = 6'b001010;
  localparam logic [5:0] OP_ADDI = 6'b010000, OP_SUBI = 6'b010010;
  localparam logic [5:0] OP_ANDI = 6'b010100, OP_ORI  = 6'b010101, OP_XORI = 6'b010110;
  localparam logic [5:0] OP_SLLI = 6'b010111, OP_SRLI = 6'b011000, OP_SRAI = 6'b011001;
  localparam logic [5:0] OP_BEQZ = 6'b100000, OP_BNEZ = 6'b100001;
  localparam logic [5:0] OP_J    = 6'b100010, OP_JAL  = 6'b100100;
  localparam logic [5:0] OP_JR   = 6'b100101, OP_JALR = 6'b100011;
  localparam logic [5:0] OP_SEQ  = 6'b110000, OP_ADD  = 6'b110001, OP_SUB  = 6'b110010;
  localparam logic [5:0] OP_AND  = 6'b110011, OP_OR   = 6'b110100, OP_XOR  = 6'b110101;
  localparam logic [5:0] OP_SLT  = 6'b110110;

  logic [31:0] rf [NUM_REGS];
  logic [31:0] pc_q, ifid_inst, ifid_pc, idex_inst, idex_pc, idex_a, idex_b;
  logic [31:0] exmem_res, exmem_data, exmem_target, memwb_val;
  logic        exmem_taken, exmem_jump, exmem_we, exmem_load, exmem_store, memwb_we;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] id_a, id_b, ex_res, ex_target, ex_simm, ex_zimm;
  logic        ex_taken, ex_jump, ex_we, ex_load, ex_store, redirect;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic [5:0]  ex_op;

  // Same-cycle WB bypass so a reader three slots behind its producer sees the new value.
  assign id_rs1 = ifid_inst[25:21];
  assign id_rs2 = ifid_inst[20:16];
  always_comb begin
    id_a = rf[id_rs1];
    id_b = rf[id_rs2];
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == id_rs1) id_a = memwb_val;
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == id_rs2) id_b = memwb_val;
  end

  assign ex_op   = idex_inst[31:26];
  assign ex_simm = {{16{idex_inst[15]}}, idex_inst[15:0]};
  assign ex_zimm = {16'd0, idex_inst[15:0]};

  always_comb begin
    ex_res    = '0;
    ex_we     = 1'b0;
    ex_rd     = idex_inst[20:16];
    ex_target = idex_pc + 32'd4 + ex_simm;
    ex_taken  = 1'b0;
    ex_jump   = 1'b0;
    ex_load   = 1'b0;
    ex_store  = 1'b0;
    case (ex_op)
      OP_LW:   begin ex_res = idex_a + ex_simm; ex_we = 1'b1; ex_load = 1'b1; end
      OP_SW:   begin ex_res = idex_a + ex_simm; ex_store = 1'b1; end
      OP_ADDI: begin ex_res = idex_a + ex_simm; ex_we = 1'b1; end
      OP_SUBI: begin ex_res = idex_a - ex_simm; ex_we = 1'b1; end
      OP_ANDI: begin ex_res = idex_a & ex_zimm; ex_we = 1'b1; end
      OP_ORI:  begin ex_res = idex_a | ex_zimm; ex_we = 1'b1; end
      OP_XORI: begin ex_res = idex_a ^ ex_zimm; ex_we = 1'b1; end
      OP_SLLI: begin ex_res = idex_a << idex_inst[4:0]; ex_we = 1'b1; end
      OP_SRLI: begin ex_res = idex_a >> idex_inst[4:0]; ex_we = 1'b1; end
      OP_SRAI: begin ex_res = $unsigned($signed(idex_a) >>> idex_inst[4:0]); ex_we = 1'b1; end
      OP_BEQZ: ex_taken = (idex_a == 32'd0);
      OP_BNEZ: ex_taken = (idex_a != 32'd0);
      OP_J:    begin
        ex_jump   = 1'b1;
        ex_target = idex_pc + 32'd4 + {{6{idex_inst[25]}}, idex_inst[25:0]};
      end
      OP_JAL:  begin
        ex_jump   = 1'b1;
        ex_target = idex_pc + 32'd4 + {{6{idex_inst[25]}}, idex_inst[25:0]};
        ex_res    = idex_pc + 32'd8;
        ex_we     = 1'b1;
        ex_rd     = 5'd31;
      end
      OP_JR:   begin ex_jump = 1'b1; ex_target = idex_a; end
      OP_JALR: begin
        ex_jump   = 1'b1;
        ex_target = idex_a;
        ex_res    = idex_pc + 32'd8;
        ex_we     = 1'b1;
        ex_rd     = 5'd31;
      end
      OP_SEQ, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
        ex_we = 1'b1;
        ex_rd = idex_inst[15:11];
        case (ex_op)
          OP_SEQ:  ex_res = {31'd0, idex_a == idex_b};
          OP_ADD:  ex_res = idex_a + idex_b;
          OP_SUB:  ex_res = idex_a - idex_b;
          OP_AND:  ex_res = idex_a & idex_b;
          OP_OR:   ex_res = idex_a | idex_b;
          OP_XOR:  ex_res = idex_a ^ idex_b;
          default: ex_res = {31'd0, $signed(idex_a) < $signed(idex_b)};
        endcase
      end
      default: ;
    endcase
  end

  assign redirect = exmem_taken | exmem_jump;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_PC;
      ifid_inst    <= '0;
      ifid_pc      <= '0;
      idex_inst    <= '0;
      idex_pc      <= '0;
      idex_a       <= '0;
      idex_b       <= '0;
      exmem_res    <= '0;
      exmem_data   <= '0;
      exmem_target <= '0;
      exmem_taken  <= 1'b0;
      exmem_jump   <= 1'b0;
      exmem_we     <= 1'b0;
      exmem_load   <= 1'b0;
      exmem_store  <= 1'b0;
      exmem_rd     <= '0;
      memwb_val    <= '0;
      memwb_we     <= 1'b0;
      memwb_rd     <= '0;
    end else begin
      memwb_val <= exmem_load ? bus.memdata_in : exmem_res;
      memwb_we  <= exmem_we;
      memwb_rd  <= exmem_rd;
      if (redirect) begin
        // The redirecting instruction itself still retires (JAL/JALR link write).
        pc_q         <= exmem_target;
        ifid_inst    <= '0;
        ifid_pc      <= '0;
        idex_inst    <= '0;
        idex_pc      <= '0;
        idex_a       <= '0;
        idex_b       <= '0;
        exmem_res    <= '0;
        exmem_data   <= '0;
        exmem_target <= '0;
        exmem_taken  <= 1'b0;
        exmem_jump   <= 1'b0;
        exmem_we     <= 1'b0;
        exmem_load   <= 1'b0;
        exmem_store  <= 1'b0;
        exmem_rd     <= '0;
      end else begin
        pc_q         <= pc_q + 32'd4;
        ifid_inst    <= bus.inst_in;
        ifid_pc      <= pc_q;
        idex_inst    <= ifid_inst;
        idex_pc      <= ifid_pc;
        idex_a       <= id_a;
        idex_b       <= id_b;
        exmem_res    <= ex_res;
        exmem_data   <= idex_b;
        exmem_target <= ex_target;
        exmem_taken  <= ex_taken;
        exmem_jump   <= ex_jump;
        exmem_we     <= ex_we;
        exmem_load   <= ex_load;
        exmem_store  <= ex_store;
        exmem_rd     <= ex_rd;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (memwb_we && memwb_rd != 5'd0) begin
      rf[memwb_rd] <= memwb_val;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.mem_addr    = exmem_res;
  assign bus.memdata_out = exmem_data;
  assign bus.mem_wr_en   = exmem_store;
  assign alu_out34       = exmem_res;
  assign alu_branch      = exmem_target;
  assign branch_en       = exmem_taken;
  assign jump_en         = exmem_jump;

  assign regs1  = rf[1];  assign regs2  = rf[2];  assign regs3  = rf[3];  assign regs4  = rf[4];
  assign regs5  = rf[5];  assign regs6  = rf[6];  assign regs7  = rf[7];  assign regs8  = rf[8];
  assign regs9  = rf[9];  assign regs10 = rf[10]; assign regs11 = rf[11]; assign regs12 = rf[12];
  assign regs13 = rf[13]; assign regs14 = rf[14]; assign regs15 = rf[15]; assign regs16 = rf[16];
  assign regs17 = rf[17]; assign regs18 = rf[18]; assign regs19 = rf[19]; assign regs20 = rf[20];
  assign regs21 = rf[21]; assign regs22 = rf[22]; assign regs23 = rf[23]; assign regs24 = rf[24];
  assign regs25 = rf[25]; assign regs26 = rf[26]; assign regs27 = rf[27]; assign regs28 = rf[28];
  assign regs29 = rf[29]; assign regs30 = rf[30]; assign regs31 = rf[31];
endmodule

// File: tb/tb_dlx_pipeline.sv
// tb/tb_dlx_pipeline.sv - directed-program bench for dlx_pipeline with ROM/RAM models
module tb_dlx_pipeline;
  localparam logic [5:0] NOP  = 6'b000000, LW   = 6'b000101, SW   = 6'b001010;
  localparam logic [5:0] ADDI = 6'b010000, SUBI = 6'b010010, XORI = 6'b010110;
  localparam logic [5:0] SLLI = 6'b010111, SRLI = 6'b011000, SRAI = 6'b011001;
  localparam logic [5:0] BEQZ = 6'b100000, BNEZ = 6'b100001, JALR = 6'b100011;
  localparam logic [5:0] SEQ  = 6'b110000, SUB  = 6'b110010, AND_ = 6'b110011;
  localparam logic [5:0] SLT  = 6'b110110;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ram_clear = 1'b0;
  logic        branch_en, jump_en;
  logic [31:0] alu_branch, alu_out34;
  logic [31:0] r [1:31];
  logic [31:0] rom [0:127];
  logic [31:0] ram [0:63];
  int          n_checks = 0;
  int          n_errors = 0;

  dlx_pipeline_if bus();

  dlx_pipeline dut (
    .clock(clock), .reset(reset), .bus(bus),
    .regs1(r[1]),   .regs2(r[2]),   .regs3(r[3]),   .regs4(r[4]),   .regs5(r[5]),
    .regs6(r[6]),   .regs7(r[7]),   .regs8(r[8]),   .regs9(r[9]),   .regs10(r[10]),
    .regs11(r[11]), .regs12(r[12]), .regs13(r[13]), .regs14(r[14]), .regs15(r[15]),
    .regs16(r[16]), .regs17(r[17]), .regs18(r[18]), .regs19(r[19]), .regs20(r[20]),
    .regs21(r[21]), .regs22(r[22]), .regs23(r[23]), .regs24(r[24]), .regs25(r[25]),
    .regs26(r[26]), .regs27(r[27]), .regs28(r[28]), .regs29(r[29]), .regs30(r[30]),
    .regs31(r[31]),
    .branch_en(branch_en), .jump_en(jump_en), .alu_branch(alu_branch), .alu_out34(alu_out34)
  );

  always #5 clock = ~clock;

  assign bus.inst_in    = rom[bus.pc[8:2]];
  assign bus.memdata_in = ram[bus.mem_addr[7:2]];

  always @(posedge clock) begin
    if (ram_clear) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (bus.mem_wr_en) begin
      ram[bus.mem_addr[7:2]] <= bus.memdata_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rd, input logic [15:0] imm);
    return {op, rs1, rd, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd);
    return {op, rs1, rs2, rd, 11'd0};
  endfunction

  task automatic begin_phase();
    reset = 1'b0;
    ram_clear = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = {NOP, 26'd0};
    @(negedge clock);
    ram_clear = 1'b0;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [31:0] acc;
    int          cnt;
    bit          took;

    // Reset state and pc sequencing
    begin_phase();
    repeat (2) @(negedge clock);
    acc = '0;
    for (int i = 1; i < 32; i++) acc = acc | r[i];
    check("reset_pc", bus.pc, 32'h0);
    check("reset_regs", acc, 32'h0);
    check("reset_wr_en", {31'd0, bus.mem_wr_en}, 32'h0);
    check("reset_br_jmp", {30'd0, branch_en, jump_en}, 32'h0);
    check("reset_alu_out34", alu_out34, 32'h0);
    reset = 1'b1;
    check("pc_after_release", bus.pc, 32'h0);
    run(1); check("pc_step1", bus.pc, 32'h4);
    run(1); check("pc_step2", bus.pc, 32'h8);

    // ADDI dependency with three NOPs
    begin_phase();
    rom[0] = enc_i(ADDI, 5'd1, 5'd2, 16'd15);
    rom[4] = enc_i(ADDI, 5'd2, 5'd3, 16'd15);
    release_reset();
    run(14);
    check("addi_r2", r[2], 32'd15);
    check("addi_r3", r[3], 32'd30);

    // Store, load, dependent add
    begin_phase();
    rom[0]  = enc_i(ADDI, 5'd0, 5'd2, 16'd15);
    rom[4]  = enc_i(SW,   5'd8, 5'd2, 16'd8);
    rom[8]  = enc_i(LW,   5'd8, 5'd4, 16'd8);
    rom[12] = enc_i(ADDI, 5'd4, 5'd5, 16'd14);
    release_reset();
    cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (bus.mem_wr_en) begin
        cnt++;
        check("sw_addr", bus.mem_addr, 32'd8);
        check("sw_data", bus.memdata_out, 32'd15);
      end
    end
    check("sw_strobe_count", cnt, 32'd1);
    check("ram_word2", ram[2], 32'd15);
    check("lw_r4", r[4], 32'd15);
    check("lw_use_r5", r[5], 32'd29);

    // Not-taken BNEZ, then taken BEQZ squashing three younger instructions
    begin_phase();
    rom[4]  = enc_i(BNEZ, 5'd10, 5'd0, 16'd16);
    rom[5]  = enc_i(ADDI, 5'd0, 5'd8, 16'd3);
    rom[8]  = enc_i(BEQZ, 5'd10, 5'd0, 16'd16);
    rom[9]  = enc_i(ADDI, 5'd0, 5'd1, 16'd1);
    rom[10] = enc_i(ADDI, 5'd0, 5'd2, 16'd1);
    rom[11] = enc_i(ADDI, 5'd0, 5'd3, 16'd1);
    rom[12] = enc_i(ADDI, 5'd0, 5'd7, 16'd9);
    rom[13] = enc_i(ADDI, 5'd0, 5'd6, 16'd7);
    release_reset();
    cnt = 0; took = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (took) begin check("beqz_next_pc", bus.pc, 32'h34); took = 1'b0; end
      if (branch_en) begin
        cnt++; took = 1'b1;
        check("beqz_target", alu_branch, 32'h34);
      end
    end
    check("branch_en_cycles", cnt, 32'd1);
    check("bnez_fallthrough_r8", r[8], 32'd3);
    acc = r[1] | r[2] | r[3] | r[7];
    check("beqz_squashed", acc, 32'h0);
    check("beqz_target_exec_r6", r[6], 32'd7);

    // JALR with link
    begin_phase();
    rom[0]  = enc_i(ADDI, 5'd0, 5'd11, 16'h0100);
    rom[16] = enc_i(JALR, 5'd11, 5'd0, 16'd0);
    rom[17] = enc_i(ADDI, 5'd0, 5'd1, 16'd1);
    rom[18] = enc_i(ADDI, 5'd0, 5'd2, 16'd1);
    rom[19] = enc_i(ADDI, 5'd0, 5'd3, 16'd1);
    rom[64] = enc_i(ADDI, 5'd0, 5'd13, 16'd5);
    release_reset();
    cnt = 0; took = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (took) begin check("jalr_next_pc", bus.pc, 32'h100); took = 1'b0; end
      if (jump_en) begin
        cnt++; took = 1'b1;
        check("jalr_target", alu_branch, 32'h100);
      end
    end
    check("jump_en_cycles", cnt, 32'd1);
    check("jalr_link_r31", r[31], 32'h48);
    acc = r[1] | r[2] | r[3];
    check("jalr_squashed", acc, 32'h0);
    check("jalr_target_exec_r13", r[13], 32'd5);

    // Shifts, SEQ, write to R0
    begin_phase();
    rom[0]  = enc_i(ADDI, 5'd0, 5'd4, 16'hFFC0);
    rom[4]  = enc_i(SRAI, 5'd4, 5'd28, 16'd5);
    rom[5]  = enc_i(SLLI, 5'd4, 5'd12, 16'd5);
    rom[6]  = enc_r(SEQ, 5'd4, 5'd4, 5'd9);
    rom[7]  = enc_i(ADDI, 5'd0, 5'd0, 16'd5);
    rom[11] = enc_i(ADDI, 5'd0, 5'd14, 16'd1);
    release_reset();
    run(20);
    check("addi_neg_r4", r[4], 32'hFFFF_FFC0);
    check("srai_r28", r[28], 32'hFFFF_FFFE);
    check("slli_r12", r[12], 32'hFFFF_F800);
    check("seq_r9", r[9], 32'd1);
    check("r0_stays_zero", r[14], 32'd1);

    // Mixed ALU ops and an undefined opcode
    begin_phase();
    rom[0]  = enc_i(ADDI, 5'd0, 5'd1, 16'hFFFD);
    rom[1]  = enc_i(ADDI, 5'd0, 5'd2, 16'd5);
    rom[5]  = enc_r(SLT, 5'd1, 5'd2, 5'd3);
    rom[6]  = enc_r(SUB, 5'd2, 5'd1, 5'd4);
    rom[7]  = enc_i(XORI, 5'd2, 5'd5, 16'hFFFF);
    rom[8]  = enc_i(SRLI, 5'd1, 5'd6, 16'd28);
    rom[9]  = enc_i(SUBI, 5'd2, 5'd7, 16'd7);
    rom[10] = enc_r(AND_, 5'd1, 5'd2, 5'd8);
    rom[11] = enc_i(6'b111111, 5'd2, 5'd10, 16'd1);
    release_reset();
    run(20);
    check("slt_r3", r[3], 32'd1);
    check("sub_r4", r[4], 32'd8);
    check("xori_r5", r[5], 32'h0000_FFFA);
    check("srli_r6", r[6], 32'h0000_000F);
    check("subi_r7", r[7], 32'hFFFF_FFFE);
    check("and_r8", r[8], 32'd5);
    check("undef_op_r10", r[10], 32'd0);

    // Asynchronous reset while a store sits in MEM
    begin_phase();
    rom[0] = enc_i(ADDI, 5'd0, 5'd1, 16'd7);
    rom[4] = enc_i(SW, 5'd0, 5'd1, 16'd12);
    release_reset();
    run(7);
    check("midrst_sw_in_mem", {31'd0, bus.mem_wr_en}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst_pc", bus.pc, 32'h0);
    check("midrst_wr_en", {31'd0, bus.mem_wr_en}, 32'h0);
    check("midrst_r1", r[1], 32'h0);
    run(2);
    check("midrst_no_store", ram[3], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
